// File: rtl/lcd_bus_receiver.sv
// HD44780-style responder for the 8-bit LCD write bus: synchronises RS/E/D, decodes
// bytes on E falling edges, and keeps an 80-cell DDRAM image with a registered read port.
module lcd_bus_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CLEAR_FILL  = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RS,
  input  logic       E,
  input  logic [7:0] D,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic [6:0] addr,
  output logic       evt_valid,
  output logic       evt_rs,
  output logic [7:0] evt_data,
  output logic       overrun
);

  localparam int unsigned NCELLS   = 80;
  localparam logic [6:0]  LAST_IDX = 7'(NCELLS - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                      r_state;
  logic [SYNC_STAGES-1:0]      r_e_sync;
  logic [SYNC_STAGES-1:0]      r_rs_sync;
  logic [SYNC_STAGES-1:0][7:0] r_d_sync;
  logic                        r_e_dly;
  logic                        r_rs_dly;
  logic [7:0]                  r_d_dly;
  logic                        w_fall;

  logic [7:0] r_ddram [NCELLS];
  logic [6:0] r_clr_idx;
  logic       r_busy;
  logic       r_display_on;
  logic       r_cursor_on;
  logic       r_blink_on;
  logic       r_two_line;
  logic       r_inc_mode;
  logic [6:0] r_addr;
  logic       r_evt_valid;
  logic       r_evt_rs;
  logic [7:0] r_evt_data;
  logic       r_overrun;
  logic [7:0] r_rd_data;

  logic [7:0] w_wr_cell;
  logic [7:0] w_rd_cell;
  logic       w_mem_we;
  logic [6:0] w_mem_idx;
  logic [7:0] w_mem_wdata;

  // Returns {valid, cell index} for a DDRAM address in the current line mode.
  function automatic logic [7:0] f_cell(input logic [6:0] a, input logic two_ln);
    logic [7:0] res;
    res = '0;
    if (two_ln) begin
      if (a < 7'h28)
        res = {1'b1, a};
      else if (a >= 7'h40 && a < 7'h68)
        res = {1'b1, a - 7'd24};
    end else if (a < 7'(NCELLS)) begin
      res = {1'b1, a};
    end
    return res;
  endfunction

  function automatic logic [6:0] f_step(input logic [6:0] a, input logic up, input logic two_ln);
    logic [6:0] nxt;
    nxt = up ? a + 7'd1 : a - 7'd1;
    if (two_ln) begin
      if (up && a == 7'h27)       nxt = 7'h40;
      else if (up && a == 7'h67)  nxt = 7'h00;
      else if (!up && a == 7'h00) nxt = 7'h67;
      else if (!up && a == 7'h40) nxt = 7'h27;
    end else begin
      if (up && a == LAST_IDX)    nxt = 7'h00;
      else if (!up && a == 7'h00) nxt = LAST_IDX;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_sync  <= '0;
      r_rs_sync <= '0;
      r_d_sync  <= '0;
      r_e_dly   <= 1'b0;
      r_rs_dly  <= 1'b0;
      r_d_dly   <= '0;
    end else begin
      r_e_sync  <= {r_e_sync[SYNC_STAGES-2:0], E};
      r_rs_sync <= {r_rs_sync[SYNC_STAGES-2:0], RS};
      r_d_sync  <= {r_d_sync[SYNC_STAGES-2:0], D};
      r_e_dly   <= r_e_sync[SYNC_STAGES-1];
      r_rs_dly  <= r_rs_sync[SYNC_STAGES-1];
      r_d_dly   <= r_d_sync[SYNC_STAGES-1];
    end
  end

  // RS/D are delayed one extra stage so they align with the E sample taken before the fall.
  assign w_fall    = r_e_dly & ~r_e_sync[SYNC_STAGES-1];
  assign w_wr_cell = f_cell(r_addr, r_two_line);
  assign w_rd_cell = f_cell(rd_addr, r_two_line);

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = '0;
    w_mem_wdata = CLEAR_FILL;
    if (r_state == ST_CLEAR) begin
      w_mem_we  = 1'b1;
      w_mem_idx = r_clr_idx;
    end else if (w_fall && r_rs_dly && w_wr_cell[7]) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = w_wr_cell[6:0];
      w_mem_wdata = r_d_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_ddram[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rd_data <= '0;
    else if (w_rd_cell[7])
      r_rd_data <= r_ddram[w_rd_cell[6:0]];
    else
      r_rd_data <= 8'h20;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_CLEAR;
      r_clr_idx    <= '0;
      r_busy       <= 1'b1;
      r_display_on <= 1'b0;
      r_cursor_on  <= 1'b0;
      r_blink_on   <= 1'b0;
      r_two_line   <= 1'b0;
      r_inc_mode   <= 1'b1;
      r_addr       <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_rs     <= 1'b0;
      r_evt_data   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_evt_valid <= w_fall;
      if (w_fall) begin
        r_evt_rs   <= r_rs_dly;
        r_evt_data <= r_d_dly;
      end
      case (r_state)
        ST_CLEAR: begin
          r_addr     <= '0;
          r_inc_mode <= 1'b1;
          if (w_fall)
            r_overrun <= 1'b1;
          if (r_clr_idx == LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 7'd1;
          end
        end
        ST_IDLE: begin
          if (w_fall) begin
            if (r_rs_dly) begin
              r_addr <= f_step(r_addr, r_inc_mode, r_two_line);
            end else begin
              casez (r_d_dly)
                8'b1???????: r_addr <= r_d_dly[6:0];
                8'b01??????: ;
                8'b001?????: r_two_line <= r_d_dly[3];
                8'b0001????: begin
                  if (!r_d_dly[3])
                    r_addr <= f_step(r_addr, r_d_dly[2], r_two_line);
                end
                8'b00001???: begin
                  r_display_on <= r_d_dly[2];
                  r_cursor_on  <= r_d_dly[1];
                  r_blink_on   <= r_d_dly[0];
                end
                8'b000001??: r_inc_mode <= r_d_dly[1];
                8'b0000001?: r_addr <= '0;
                8'b00000001: begin
                  r_state    <= ST_CLEAR;
                  r_busy     <= 1'b1;
                  r_clr_idx  <= '0;
                  r_addr     <= '0;
                  r_inc_mode <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign busy       = r_busy;
  assign display_on = r_display_on;
  assign cursor_on  = r_cursor_on;
  assign blink_on   = r_blink_on;
  assign two_line   = r_two_line;
  assign inc_mode   = r_inc_mode;
  assign addr       = r_addr;
  assign evt_valid  = r_evt_valid;
  assign evt_rs     = r_evt_rs;
  assign evt_data   = r_evt_data;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed bus writes, a cycle-level reference model of the
// LCD controller, per-cycle output comparison and literal spot checks.
module tb_lcd_bus_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       RS = 1'b0;
  logic       E = 1'b0;
  logic [7:0] D = '0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       busy, display_on, cursor_on, blink_on, two_line, inc_mode;
  logic [6:0] addr;
  logic       evt_valid, evt_rs, overrun;
  logic [7:0] evt_data;

  lcd_bus_receiver #(.SYNC_STAGES(2), .CLEAR_FILL(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .RS(RS), .E(E), .D(D), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .inc_mode(inc_mode), .addr(addr),
    .evt_valid(evt_valid), .evt_rs(evt_rs), .evt_data(evt_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int at; bit rs; logic [7:0] d; } wr_t;
  wr_t        pq[$];
  logic [7:0] mem [80];
  bit         known [80];
  bit         m_disp, m_cur, m_blink, m_two, m_inc, m_ovr, m_evt, m_evt_rs;
  logic [7:0] m_evt_data, m_rd;
  bit         m_rd_known;
  int         m_addr, m_clr;
  int         last_at;

  function automatic int cell_of(input int a, input bit two);
    if (two) begin
      if ((a % 64) < 40) return (a / 64) * 40 + (a % 64);
      return -1;
    end
    return (a < 80) ? a : -1;
  endfunction

  function automatic int addr_of(input int pos, input bit two);
    if (two && pos >= 40) return 64 + pos - 40;
    return pos;
  endfunction

  function automatic int step(input int a, input bit up, input bit two);
    int c;
    c = cell_of(a, two);
    if (c < 0) return (a + (up ? 1 : 127)) % 128;
    return addr_of((c + (up ? 1 : 79)) % 80, two);
  endfunction

  task automatic model_apply(input bit rs, input logic [7:0] d);
    int c, hb;
    if (rs) begin
      c = cell_of(m_addr, m_two);
      if (c >= 0) begin
        mem[c] = d;
        known[c] = 1'b1;
      end
      m_addr = step(m_addr, m_inc, m_two);
    end else begin
      hb = -1;
      for (int b = 7; b >= 0; b--)
        if (hb < 0 && d[b]) hb = b;
      case (hb)
        7: m_addr = int'(d) - 128;
        5: m_two = d[3];
        4: if (!d[3]) m_addr = step(m_addr, d[2], m_two);
        3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        2: m_inc = d[1];
        1: m_addr = 0;
        0: begin m_clr = 80; m_addr = 0; m_inc = 1'b1; end
        default: ;
      endcase
    end
  endtask

  always @(negedge rst_n) begin
    pq.delete();
    m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0; m_inc = 1; m_ovr = 0;
    m_evt = 0; m_evt_rs = 0; m_evt_data = '0; m_rd = '0; m_rd_known = 1;
    m_addr = 0; m_clr = 80;
  end

  always @(posedge clk) begin
    int c;
    bit was_busy;
    wr_t w;
    cyc++;
    if (rst_n) begin
      c = cell_of(int'(rd_addr), m_two);
      if (c < 0) begin
        m_rd = 8'h20;
        m_rd_known = 1'b1;
      end else begin
        m_rd = mem[c];
        m_rd_known = known[c];
      end
      was_busy = (m_clr > 0);
      m_evt = 1'b0;
      if (was_busy) begin
        mem[80 - m_clr] = 8'h20;
        known[80 - m_clr] = 1'b1;
        m_clr--;
      end
      if (pq.size() > 0 && pq[0].at == cyc) begin
        w = pq.pop_front();
        m_evt = 1'b1;
        m_evt_rs = w.rs;
        m_evt_data = w.d;
        if (was_busy) m_ovr = 1'b1;
        else model_apply(w.rs, w.d);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("evt_valid", evt_valid, m_evt);
      chk("evt_rs", evt_rs, m_evt_rs);
      chk("evt_data", evt_data, m_evt_data);
      chk("busy", busy, m_clr > 0);
      chk("display_on", display_on, m_disp);
      chk("cursor_on", cursor_on, m_cur);
      chk("blink_on", blink_on, m_blink);
      chk("two_line", two_line, m_two);
      chk("inc_mode", inc_mode, m_inc);
      chk("addr", addr, m_addr);
      chk("overrun", overrun, m_ovr);
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
    end
  end

  task automatic wr(input bit rs, input logic [7:0] d);
    @(posedge clk); #2; RS = rs; D = d;
    @(posedge clk); #2; E = 1'b1;
    repeat (3) @(posedge clk);
    #2; E = 1'b0;
    last_at = cyc + 3;
    pq.push_back('{cyc + 3, rs, d});
    repeat (3) @(posedge clk);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp, input string nm);
    @(posedge clk); #2; rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    chk(nm, rd_data, exp);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_disp"}, display_on, 0);
    chk({tag, "_two"}, two_line, 0);
    chk({tag, "_inc"}, inc_mode, 1);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_evt"}, evt_valid, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_rd"}, rd_data, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int start_at;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: power-up clear
    repeat (79) @(posedge clk);
    @(negedge clk); chk("t1_busy_79", busy, 1);
    @(posedge clk);
    @(negedge clk); chk("t1_busy_80", busy, 0);
    chk("t1_overrun", overrun, 0);
    rd(7'h00, 8'h20, "t1_rd0");
    rd(7'h4F, 8'h20, "t1_rd79");

    // single-line wrap and invalid-addr basics
    wr(0, 8'hCF);
    wr(1, 8'h57);
    @(negedge clk); chk("s_addr_wrap", addr, 7'h00);
    rd(7'h4F, 8'h57, "s_rd_4f");

    // 2: function set, display, "Base:"
    wr(0, 8'h3C); wr(0, 8'h0C); wr(0, 8'h80);
    wr(1, 8'h42); wr(1, 8'h61); wr(1, 8'h73); wr(1, 8'h65); wr(1, 8'h3A);
    @(negedge clk);
    chk("t2_two", two_line, 1); chk("t2_disp", display_on, 1);
    chk("t2_cur", cursor_on, 0); chk("t2_addr", addr, 7'h05);
    rd(7'h00, 8'h42, "t2_rd0"); rd(7'h01, 8'h61, "t2_rd1"); rd(7'h02, 8'h73, "t2_rd2");
    rd(7'h03, 8'h65, "t2_rd3"); rd(7'h04, 8'h3A, "t2_rd4");

    // 3: line wraps
    wr(0, 8'hA7); wr(1, 8'h58); wr(1, 8'h59);
    @(negedge clk); chk("t3_addr_a", addr, 7'h41);
    rd(7'h27, 8'h58, "t3_rd27"); rd(7'h40, 8'h59, "t3_rd40");
    wr(0, 8'hE7); wr(1, 8'h58); wr(1, 8'h59);
    @(negedge clk); chk("t3_addr_b", addr, 7'h01);
    rd(7'h67, 8'h58, "t3_rd67"); rd(7'h00, 8'h59, "t3_rd00");

    // 4: write during clear
    wr(0, 8'h01);
    start_at = last_at;
    repeat (3) @(posedge clk);
    wr(1, 8'h51);
    @(negedge clk); chk("t4_overrun", overrun, 1);
    wait_idle("t4_idle");
    chk("t4_busy_len", cyc - start_at, 80);
    chk("t4_addr", addr, 0);
    rd(7'h00, 8'h20, "t4_rd0");

    // 5: decrement mode and shift
    wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h41);
    @(negedge clk); chk("t5_addr", addr, 7'h67); chk("t5_inc", inc_mode, 0);
    rd(7'h00, 8'h41, "t5_rd0");
    wr(0, 8'h14);
    @(negedge clk); chk("t5_shift", addr, 7'h00);

    // other commands, invalid address write
    wr(0, 8'h06); wr(0, 8'h0F); wr(0, 8'hB0); wr(1, 8'h5A);
    @(negedge clk); chk("x_addr", addr, 7'h31); chk("x_blink", blink_on, 1);
    rd(7'h30, 8'h20, "x_rd_invalid");
    wr(0, 8'h10); wr(0, 8'h40); wr(0, 8'h00);
    @(negedge clk); chk("x_shl", addr, 7'h30);
    wr(0, 8'h02);
    @(negedge clk); chk("x_home", addr, 7'h00);

    // 6: reset mid-strobe
    @(posedge clk); #2; RS = 1'b1; D = 8'h55; E = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b0; E = 1'b0;
    check_reset_vals("t6a");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle("t6a_idle");

    // 6: reset mid-clear
    wr(0, 8'h01);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    check_reset_vals("t6b");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_idle("t6b_idle");
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
